// File: rtl/uart_frame_packer_pkg.sv
// Shared definitions for the UART frame packer: FSM encoding and CRC-8 (poly 0x07) helpers.
package uart_frame_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DONE
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // MSB-first, unreflected, no final XOR; one byte per call.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_frame_packer_if.sv
// Byte-link handshake toward interfpga_send: data + one-cycle send pulse, busy back.
interface uart_frame_packer_if;
  logic [7:0] o_8_tx_data;
  logic       o_send;
  logic       i_busy;

  modport master (output o_8_tx_data, output o_send, input i_busy);
  modport slave  (input o_8_tx_data, input o_send, output i_busy);
endinterface

// File: rtl/uart_frame_packer_byte_fifo.sv
// First-word fall-through byte FIFO; extra pointer bit separates full from empty.
module byte_fifo #(
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       db_reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;

  logic [7:0]               mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2:0] rd_ptr;
  logic                     do_wr;
  logic                     do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                 (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);
  assign do_rd = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a push on full is accepted.
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or posedge db_reset) begin
    if (db_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_frame_packer.sv
// Buffers UART bytes and forwards them over the send/busy link, closing each frame with a CRC-8 trailer.
module uart_frame_packer
  import uart_frame_packer_pkg::*;
#(
  parameter int unsigned FRAME_LEN       = 16,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned BUSY_TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       db_reset,
  input  logic [7:0]                 i_8_data,
  input  logic                       i_valid,
  input  logic                       i_flush,
  uart_frame_packer_if.master        link,
  output logic                       o_overflow,
  output logic [7:0]                 o_8_frame_count,
  output logic                       o_busy
);

  localparam int unsigned TW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam logic [7:0]    FRAME_LEN_B = 8'(FRAME_LEN);
  localparam logic [TW-1:0] TIMEOUT_T   = TW'(BUSY_TIMEOUT);

  state_t        state;
  logic [7:0]    crc;
  logic [7:0]    payload_cnt;
  logic [7:0]    tx_data;
  logic          send;
  logic          trailer;
  logic          flush_pending;
  logic [TW-1:0] tcnt;

  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_data;
  logic          pop;

  assign pop = (state == ST_IDLE) && !fifo_empty && (payload_cnt < FRAME_LEN_B);

  byte_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk      (clk),
    .db_reset (db_reset),
    .wr_en    (i_valid),
    .wr_data  (i_8_data),
    .rd_en    (pop),
    .rd_data  (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign link.o_8_tx_data = tx_data;
  assign link.o_send      = send;
  assign o_busy           = (state != ST_IDLE) || !fifo_empty || flush_pending;

  always_ff @(posedge clk or posedge db_reset) begin
    if (db_reset) begin
      state           <= ST_IDLE;
      crc             <= CRC8_INIT;
      payload_cnt     <= '0;
      tx_data         <= '0;
      send            <= 1'b0;
      trailer         <= 1'b0;
      flush_pending   <= 1'b0;
      tcnt            <= '0;
      o_overflow      <= 1'b0;
      o_8_frame_count <= '0;
    end else begin
      send <= 1'b0;
      if (i_valid && fifo_full && !pop) o_overflow <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_data     <= fifo_data;
            crc         <= crc8_update(crc, fifo_data);
            payload_cnt <= payload_cnt + 8'd1;
            send        <= 1'b1;
            tcnt        <= '0;
            state       <= ST_PULSE;
          end else if (payload_cnt == FRAME_LEN_B ||
                       (flush_pending && fifo_empty && payload_cnt != '0)) begin
            tx_data <= crc;
            trailer <= 1'b1;
            send    <= 1'b1;
            tcnt    <= '0;
            state   <= ST_PULSE;
          end else if (flush_pending && fifo_empty) begin
            flush_pending <= 1'b0;
          end
        end
        ST_PULSE: state <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: begin
          if (link.i_busy)            state <= ST_WAIT_DONE;
          else if (tcnt == TIMEOUT_T) state <= ST_DONE;
          else                        tcnt  <= tcnt + 1'b1;
        end
        ST_WAIT_DONE: if (!link.i_busy) state <= ST_DONE;
        ST_DONE: begin
          if (trailer) begin
            crc             <= CRC8_INIT;
            payload_cnt     <= '0;
            flush_pending   <= 1'b0;
            trailer         <= 1'b0;
            o_8_frame_count <= o_8_frame_count + 8'd1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Placed last so a strobe landing on a clearing cycle is never lost.
      if (i_flush) flush_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed bench: a FRAME_LEN=9 and a FRAME_LEN=16 packer share stimulus, each with its own busy responder.
module tb_uart_frame_packer;

  logic       clk = 1'b0;
  logic       db_reset;
  logic [7:0] i_8_data;
  logic       i_valid;
  logic       i_flush;
  logic       ovf9, ovf16, busy9, busy16;
  logic [7:0] fc9, fc16;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busy_mode = 0;   // 0: busy 10 cycles per send, 1: hold busy, 2: busy tied low
  int bc9 = 0;
  int bc16 = 0;

  logic [7:0] q9[$];
  logic [7:0] q16[$];
  int         t16[$];

  uart_frame_packer_if link9();
  uart_frame_packer_if link16();

  uart_frame_packer #(.FRAME_LEN(9)) dut9 (
    .clk(clk), .db_reset(db_reset), .i_8_data(i_8_data), .i_valid(i_valid), .i_flush(i_flush),
    .link(link9), .o_overflow(ovf9), .o_8_frame_count(fc9), .o_busy(busy9)
  );

  uart_frame_packer #(.FRAME_LEN(16)) dut16 (
    .clk(clk), .db_reset(db_reset), .i_8_data(i_8_data), .i_valid(i_valid), .i_flush(i_flush),
    .link(link16), .o_overflow(ovf16), .o_8_frame_count(fc16), .o_busy(busy16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (link9.o_send) q9.push_back(link9.o_8_tx_data);
    if (link16.o_send) begin
      q16.push_back(link16.o_8_tx_data);
      t16.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (db_reset || busy_mode == 2) begin
      link9.i_busy <= 1'b0; link16.i_busy <= 1'b0; bc9 <= 0; bc16 <= 0;
    end else begin
      if (link9.o_send) begin link9.i_busy <= 1'b1; bc9 <= (busy_mode == 0) ? 10 : 0; end
      else if (busy_mode == 0) begin
        if (bc9 > 1) bc9 <= bc9 - 1; else begin bc9 <= 0; link9.i_busy <= 1'b0; end
      end
      if (link16.o_send) begin link16.i_busy <= 1'b1; bc16 <= (busy_mode == 0) ? 10 : 0; end
      else if (busy_mode == 0) begin
        if (bc16 > 1) bc16 <= bc16 - 1; else begin bc16 <= 0; link16.i_busy <= 1'b0; end
      end
    end
  end

  function automatic logic [7:0] ref_crc8(input logic [7:0] c, input logic [7:0] d);
    logic fb;
    for (int k = 7; k >= 0; k--) begin
      fb = c[7] ^ d[k];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_8_data = b; i_valid = 1'b1;
    tick(1);
    i_valid = 1'b0;
  endtask

  task automatic flush_pulse;
    i_flush = 1'b1;
    tick(1);
    i_flush = 1'b0;
  endtask

  task automatic clear_logs;
    q9.delete(); q16.delete(); t16.delete();
  endtask

  task automatic do_reset;
    db_reset = 1'b1;
    tick(2);
    db_reset = 1'b0;
    busy_mode = 0;
    clear_logs();
    tick(2);
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 20 && n < budget) begin
      tick(1);
      n++;
      quiet = (!busy9 && !busy16) ? quiet + 1 : 0;
    end
    vectors++;
    if (quiet < 20) begin
      miscompares++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic test_reset;
    db_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_8_data = 8'h00;
    tick(3);
    vectors += 8;
    if (link9.o_8_tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_tx9: got %h want 00", link9.o_8_tx_data); end
    if (link9.o_send !== 1'b0)       begin miscompares++; $display("FAIL rst_send9: got %b want 0", link9.o_send); end
    if (ovf9 !== 1'b0)               begin miscompares++; $display("FAIL rst_ovf9: got %b want 0", ovf9); end
    if (fc9 !== 8'h00)               begin miscompares++; $display("FAIL rst_fc9: got %h want 00", fc9); end
    if (busy9 !== 1'b0)              begin miscompares++; $display("FAIL rst_busy9: got %b want 0", busy9); end
    if (link16.o_8_tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_tx16: got %h want 00", link16.o_8_tx_data); end
    if (link16.o_send !== 1'b0)      begin miscompares++; $display("FAIL rst_send16: got %b want 0", link16.o_send); end
    if (busy16 !== 1'b0)             begin miscompares++; $display("FAIL rst_busy16: got %b want 0", busy16); end
    db_reset = 1'b0;
    clear_logs();
    tick(3);
    vectors++;
    if (busy9 !== 1'b0) begin miscompares++; $display("FAIL post_rst_busy9: got %b want 0", busy9); end
  endtask

  task automatic send_digits;
    for (int i = 0; i < 9; i++) begin
      send_byte(8'h31 + 8'(i));
      tick(49);
    end
  endtask

  task automatic check_digit_frame(input string name);
    logic [7:0] exp;
    vectors += 3;
    if (q9.size() !== 10) begin miscompares++; $display("FAIL %s_count: got %0d sends want 10", name, q9.size()); end
    if (fc9 !== 8'd1)     begin miscompares++; $display("FAIL %s_fc: got %0d want 1", name, fc9); end
    if (ovf9 !== 1'b0)    begin miscompares++; $display("FAIL %s_ovf: got %b want 0", name, ovf9); end
    if (q9.size() == 10) begin
      for (int i = 0; i < 9; i++) begin
        exp = 8'h31 + 8'(i);
        vectors++;
        if (q9[i] !== exp) begin miscompares++; $display("FAIL %s_data%0d: got %h want %h", name, i, q9[i], exp); end
      end
      vectors++;
      if (q9[9] !== 8'hF4) begin miscompares++; $display("FAIL %s_crc: got %h want f4", name, q9[9]); end
    end
  endtask

  task automatic test_basic_frame;
    do_reset();
    send_byte(8'h31);
    vectors++;
    if (link9.o_send !== 1'b0) begin miscompares++; $display("FAIL latency_early: got %b want 0", link9.o_send); end
    tick(1);
    vectors++;
    if (link9.o_send !== 1'b1) begin miscompares++; $display("FAIL latency_pulse: got %b want 1", link9.o_send); end
    tick(48);
    for (int i = 1; i < 9; i++) begin
      send_byte(8'h31 + 8'(i));
      tick(49);
    end
    wait_quiet(300, "basic_idle");
    check_digit_frame("basic");
    vectors += 2;
    if (q16.size() !== 9) begin miscompares++; $display("FAIL basic_len16_count: got %0d want 9", q16.size()); end
    if (fc16 !== 8'd0)    begin miscompares++; $display("FAIL basic_len16_fc: got %0d want 0", fc16); end
  endtask

  task automatic test_early_flush;
    do_reset();
    send_byte(8'h01);
    tick(1);
    flush_pulse();
    wait_quiet(200, "flush_idle");
    vectors += 2;
    if (q16.size() !== 2) begin miscompares++; $display("FAIL flush_count: got %0d want 2", q16.size()); end
    if (fc16 !== 8'd1)    begin miscompares++; $display("FAIL flush_fc: got %0d want 1", fc16); end
    if (q16.size() == 2) begin
      vectors += 2;
      if (q16[0] !== 8'h01) begin miscompares++; $display("FAIL flush_data: got %h want 01", q16[0]); end
      if (q16[1] !== 8'h07) begin miscompares++; $display("FAIL flush_crc: got %h want 07", q16[1]); end
    end

    clear_logs();
    flush_pulse();
    wait_quiet(200, "empty_flush_idle");
    vectors += 2;
    if (q16.size() !== 0) begin miscompares++; $display("FAIL empty_flush_sends: got %0d want 0", q16.size()); end
    if (fc16 !== 8'd1)    begin miscompares++; $display("FAIL empty_flush_fc: got %0d want 1", fc16); end

    // A byte arriving after the strobe but before the FIFO drains joins the flushed frame.
    clear_logs();
    send_byte(8'h01);
    flush_pulse();
    send_byte(8'h02);
    wait_quiet(300, "scope_idle");
    vectors += 2;
    if (q16.size() !== 3) begin miscompares++; $display("FAIL scope_count: got %0d want 3", q16.size()); end
    if (fc16 !== 8'd2)    begin miscompares++; $display("FAIL scope_fc: got %0d want 2", fc16); end
    if (q16.size() == 3) begin
      vectors += 2;
      if (q16[1] !== 8'h02) begin miscompares++; $display("FAIL scope_data: got %h want 02", q16[1]); end
      if (q16[2] !== 8'h1B) begin miscompares++; $display("FAIL scope_crc: got %h want 1b", q16[2]); end
    end
    vectors++;
    if (fc9 !== 8'd2) begin miscompares++; $display("FAIL scope_fc9: got %0d want 2", fc9); end
  endtask

  task automatic test_overflow;
    logic [7:0] exp;
    logic [7:0] crc;
    int         min_gap;
    do_reset();
    busy_mode = 1;
    for (int i = 1; i <= 20; i++) begin
      send_byte(8'h40 + 8'(i));
      tick(3);
    end
    vectors += 3;
    if (ovf16 !== 1'b1)   begin miscompares++; $display("FAIL ovf_set: got %b want 1", ovf16); end
    if (q16.size() !== 1) begin miscompares++; $display("FAIL ovf_inflight: got %0d sends want 1", q16.size()); end
    if (busy16 !== 1'b1)  begin miscompares++; $display("FAIL ovf_busy: got %b want 1", busy16); end
    busy_mode = 0;
    wait_quiet(2000, "ovf_drain");
    crc = 8'h00;
    for (int i = 1; i <= 16; i++) crc = ref_crc8(crc, 8'h40 + 8'(i));
    vectors += 3;
    if (q16.size() !== 18) begin miscompares++; $display("FAIL ovf_count: got %0d want 18", q16.size()); end
    if (ovf16 !== 1'b1)    begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", ovf16); end
    if (fc16 !== 8'd1)     begin miscompares++; $display("FAIL ovf_fc: got %0d want 1", fc16); end
    if (q16.size() == 18) begin
      for (int i = 0; i < 16; i++) begin
        exp = 8'h41 + 8'(i);
        vectors++;
        if (q16[i] !== exp) begin miscompares++; $display("FAIL ovf_data%0d: got %h want %h", i, q16[i], exp); end
      end
      vectors += 2;
      if (q16[16] !== crc)   begin miscompares++; $display("FAIL ovf_crc: got %h want %h", q16[16], crc); end
      if (q16[17] !== 8'h51) begin miscompares++; $display("FAIL ovf_next: got %h want 51", q16[17]); end
    end
    min_gap = 1000000;
    for (int i = 1; i < t16.size(); i++)
      if (t16[i] - t16[i-1] < min_gap) min_gap = t16[i] - t16[i-1];
    vectors++;
    if (min_gap < 4) begin miscompares++; $display("FAIL back_to_back_gap: got %0d cycles want >= 4", min_gap); end
  endtask

  task automatic test_push_pop_full;
    do_reset();
    busy_mode = 1;
    for (int i = 1; i <= 17; i++) begin
      send_byte(8'h80 + 8'(i));
      tick(3);
    end
    busy_mode = 0;
    tick(2);
    send_byte(8'h99);
    vectors++;
    if (ovf16 !== 1'b0) begin miscompares++; $display("FAIL pushpop_ovf: got %b want 0", ovf16); end
    wait_quiet(2000, "pushpop_drain");
    vectors += 2;
    if (q16.size() !== 19) begin miscompares++; $display("FAIL pushpop_count: got %0d want 19", q16.size()); end
    if (ovf16 !== 1'b0)    begin miscompares++; $display("FAIL pushpop_ovf_end: got %b want 0", ovf16); end
    if (q16.size() == 19) begin
      vectors += 2;
      if (q16[17] !== 8'h91) begin miscompares++; $display("FAIL pushpop_b17: got %h want 91", q16[17]); end
      if (q16[18] !== 8'h99) begin miscompares++; $display("FAIL pushpop_b18: got %h want 99", q16[18]); end
    end
  endtask

  task automatic test_timeout;
    int gap;
    do_reset();
    busy_mode = 2;
    send_byte(8'hA5);
    send_byte(8'h5A);
    wait_quiet(1500, "timeout_idle");
    vectors += 2;
    if (q16.size() !== 2) begin miscompares++; $display("FAIL timeout_count: got %0d want 2", q16.size()); end
    if (fc16 !== 8'd0)    begin miscompares++; $display("FAIL timeout_fc: got %0d want 0", fc16); end
    if (q16.size() == 2) begin
      gap = t16[1] - t16[0];
      vectors += 3;
      if (q16[0] !== 8'hA5) begin miscompares++; $display("FAIL timeout_b0: got %h want a5", q16[0]); end
      if (q16[1] !== 8'h5A) begin miscompares++; $display("FAIL timeout_b1: got %h want 5a", q16[1]); end
      if (gap < 255 || gap > 263) begin miscompares++; $display("FAIL timeout_gap: got %0d cycles want 255..263", gap); end
    end
  endtask

  task automatic test_reset_mid_frame;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h11 + 8'(i));
      if (i < 3) tick(49);
    end
    tick(4);
    vectors += 2;
    if (link9.o_8_tx_data !== 8'h14) begin miscompares++; $display("FAIL midrst_pre_tx: got %h want 14", link9.o_8_tx_data); end
    if (busy9 !== 1'b1)              begin miscompares++; $display("FAIL midrst_pre_busy: got %b want 1", busy9); end
    db_reset = 1'b1;
    #1;
    vectors += 5;
    if (link9.o_8_tx_data !== 8'h00) begin miscompares++; $display("FAIL midrst_tx: got %h want 00", link9.o_8_tx_data); end
    if (link9.o_send !== 1'b0)       begin miscompares++; $display("FAIL midrst_send: got %b want 0", link9.o_send); end
    if (busy9 !== 1'b0)              begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy9); end
    if (fc9 !== 8'h00)               begin miscompares++; $display("FAIL midrst_fc: got %h want 00", fc9); end
    if (ovf9 !== 1'b0)               begin miscompares++; $display("FAIL midrst_ovf: got %b want 0", ovf9); end
    tick(1);
    db_reset = 1'b0;
    clear_logs();
    tick(2);
    send_digits();
    wait_quiet(300, "midrst_idle");
    check_digit_frame("midrst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_early_flush();
    test_overflow();
    test_push_pop_full();
    test_timeout();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
